// File: rtl/xfer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xfer_pkg
// Purpose  : Shared state encoding and wrapper mode constants for ram_xfer_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package xfer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        R2M  = 2'd1,
        M2R  = 2'd2,
        DONE = 2'd3
    } xfer_state_t;

    localparam logic [1:0] CH_REG2RAM = 2'b00;
    localparam logic [1:0] CH_RAM2REG = 2'b01;
    localparam logic [1:0] CH_IDLE    = 2'b10;

endpackage
`default_nettype wire

// File: rtl/ram_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_xfer_ctrl_if
// Purpose  : Request side and wrapper control side of the transfer sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_xfer_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int RAM_AW = 16,
    parameter int CNT_W  = 6
);
    logic              start;
    logic              dir;
    logic [REG_AW-1:0] reg_base;
    logic [RAM_AW-1:0] ram_base;
    logic [CNT_W-1:0]  count;

    logic [1:0]        choice;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_wen;
    logic [REG_AW-1:0] raddr1;
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic              busy;
    logic              done;

    // Requester / harness side
    modport master (
        output start, dir, reg_base, ram_base, count,
        input  choice, ram_addr, ram_wen, raddr1, we, waddr, busy, done
    );

    // Sequencer side
    modport slave (
        input  start, dir, reg_base, ram_base, count,
        output choice, ram_addr, ram_wen, raddr1, we, waddr, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/ram_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_xfer_ctrl
// Purpose  : Sequences N-word copies between regfile and block RAM via the wrapper.
// Revision : 1.0 - initial release
// ============================================================================
module ram_xfer_ctrl
    import xfer_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int RAM_AW = 16,
    parameter int CNT_W  = 6
) (
    input  logic           clk,
    input  logic           rst,
    ram_xfer_ctrl_if.slave bus
);

    xfer_state_t       r_state;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_count;
    logic [REG_AW-1:0] r_reg_base;
    logic [RAM_AW-1:0] r_ram_base;

    logic [1:0]        r_choice;
    logic [RAM_AW-1:0] r_ram_addr;
    logic              r_ram_wen;
    logic [REG_AW-1:0] r_raddr1;
    logic              r_we;
    logic [REG_AW-1:0] r_waddr;
    logic              r_busy;
    logic              r_done;

    logic [CNT_W-1:0]  w_idx_nxt;
    logic [REG_AW-1:0] w_reg_nxt;
    logic [RAM_AW-1:0] w_ram_nxt;
    logic [REG_AW-1:0] w_wb_addr;

    assign w_idx_nxt = r_idx + CNT_W'(1);
    assign w_reg_nxt = r_reg_base + REG_AW'(w_idx_nxt);
    assign w_ram_nxt = r_ram_base + RAM_AW'(w_idx_nxt);
    // Write-back in cycle j+1 targets the word whose read was issued in cycle j
    assign w_wb_addr = r_reg_base + REG_AW'(r_idx);

    // Outputs are registered for the cycle being entered, so each branch
    // loads the decode for the next state and index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_count    <= '0;
            r_reg_base <= '0;
            r_ram_base <= '0;
            r_choice   <= CH_IDLE;
            r_ram_addr <= '0;
            r_ram_wen  <= 1'b0;
            r_raddr1   <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_choice   <= CH_IDLE;
            r_ram_addr <= '0;
            r_ram_wen  <= 1'b0;
            r_raddr1   <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_idx      <= '0;
                        r_count    <= bus.count;
                        r_reg_base <= bus.reg_base;
                        r_ram_base <= bus.ram_base;
                        if (bus.count == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else if (!bus.dir) begin
                            r_state    <= R2M;
                            r_choice   <= CH_REG2RAM;
                            r_raddr1   <= bus.reg_base;
                            r_ram_addr <= bus.ram_base;
                            r_ram_wen  <= 1'b1;
                            r_busy     <= 1'b1;
                        end else begin
                            r_state    <= M2R;
                            r_choice   <= CH_RAM2REG;
                            r_ram_addr <= bus.ram_base;
                            r_busy     <= 1'b1;
                        end
                    end
                end

                R2M: begin
                    if (r_idx == r_count - CNT_W'(1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx      <= w_idx_nxt;
                        r_choice   <= CH_REG2RAM;
                        r_raddr1   <= w_reg_nxt;
                        r_ram_addr <= w_ram_nxt;
                        r_ram_wen  <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end

                M2R: begin
                    if (r_idx == r_count) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx      <= w_idx_nxt;
                        r_choice   <= CH_RAM2REG;
                        r_ram_addr <= (w_idx_nxt == r_count) ? r_ram_addr : w_ram_nxt;
                        r_we       <= 1'b1;
                        r_waddr    <= w_wb_addr;
                        r_busy     <= 1'b1;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.choice   = r_choice;
    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_wen  = r_ram_wen;
    assign bus.raddr1   = r_raddr1;
    assign bus.we       = r_we;
    assign bus.waddr    = r_waddr;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_xfer_ctrl
// Purpose  : Directed bench for ram_xfer_ctrl with a regfile/RAM wrapper model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_xfer_ctrl;

    logic clk;
    logic rst;

    ram_xfer_ctrl_if #(.REG_AW(5), .RAM_AW(16), .CNT_W(6)) bus ();

    ram_xfer_ctrl #(.REG_AW(5), .RAM_AW(16), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wrapper model: combinational regfile read, 1-cycle-latency RAM read
    logic [7:0]  rf  [0:31];
    logic [7:0]  ram [0:65535];
    logic [7:0]  ram_rdata;
    logic        pl_rf_en, pl_ram_en;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;

    always @(posedge clk) begin
        ram_rdata <= ram[bus.ram_addr];
        if (pl_ram_en)
            ram[pl_addr] <= pl_data;
        else if (bus.choice == 2'b00 && bus.ram_wen)
            ram[bus.ram_addr] <= rf[bus.raddr1];
        if (pl_rf_en)
            rf[pl_addr[4:0]] <= pl_data;
        else if (bus.choice == 2'b01 && bus.we && bus.waddr != 5'd0)
            rf[bus.waddr] <= ram_rdata;
    end

    // Packed view: [31:30] choice [29:14] ram_addr [13] ram_wen [12:8] raddr1
    //              [7] we [6:2] waddr [1] busy [0] done
    logic [31:0] obs;
    assign obs = {bus.choice, bus.ram_addr, bus.ram_wen, bus.raddr1,
                  bus.we, bus.waddr, bus.busy, bus.done};

    localparam logic [31:0] M_ALL  = 32'hFFFF_FFFF;
    localparam logic [31:0] M_CTRL = 32'hC000_2083;
    localparam logic [31:0] M_R2M  = 32'hFFFF_FF83;
    localparam logic [31:0] M_M2R  = 32'hFFFF_E0FF;
    localparam logic [31:0] M_M2R0 = 32'hFFFF_E083;
    localparam logic [31:0] IDLE_V = 32'h8000_0000;
    localparam logic [31:0] DONE_V = 32'h8000_0001;

    int n_checks;
    int n_fail;

    function automatic logic [31:0] pk(input logic [1:0] ch, input logic [15:0] ra,
                                       input logic rw, input logic [4:0] r1,
                                       input logic w, input logic [4:0] wa,
                                       input logic b, input logic d);
        return {ch, ra, rw, r1, w, wa, b, d};
    endfunction

    task automatic preload(input bit to_ram, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_addr   = a;
        pl_data   = d;
        pl_ram_en = to_ram;
        pl_rf_en  = !to_ram;
        @(negedge clk);
        pl_ram_en = 1'b0;
        pl_rf_en  = 1'b0;
    endtask

    task automatic request(input logic d, input logic [4:0] rb, input logic [15:0] mb,
                           input logic [5:0] n);
        bus.start    = 1'b1;
        bus.dir      = d;
        bus.reg_base = rb;
        bus.ram_base = mb;
        bus.count    = n;
    endtask

    task automatic test_reset;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (obs !== IDLE_V) begin
                n_fail++;
                $display("FAIL reset c%0d: got %h expected %h", c, obs, IDLE_V);
            end
            n_checks++;
            if (c == 2) request(1'b0, 5'd4, 16'h0100, 6'd2);
            if (c == 3) begin
                rst       = 1'b0;
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic test_reg2ram;
        logic [31:0] e [1:6];
        logic [31:0] m [1:6];
        logic [7:0]  d [0:3];
        e[1] = pk(2'b00, 16'h0100, 1, 5'd4, 0, 0, 1, 0); m[1] = M_R2M;
        e[2] = pk(2'b00, 16'h0101, 1, 5'd5, 0, 0, 1, 0); m[2] = M_R2M;
        e[3] = pk(2'b00, 16'h0102, 1, 5'd6, 0, 0, 1, 0); m[3] = M_R2M;
        e[4] = pk(2'b00, 16'h0103, 1, 5'd7, 0, 0, 1, 0); m[4] = M_R2M;
        e[5] = DONE_V;                                   m[5] = M_CTRL;
        e[6] = IDLE_V;                                   m[6] = M_ALL;
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        @(negedge clk);
        request(1'b0, 5'd4, 16'h0100, 6'd4);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if ((obs & m[c]) !== (e[c] & m[c])) begin
                n_fail++;
                $display("FAIL reg2ram c%0d: got %h expected %h", c, obs & m[c], e[c] & m[c]);
            end
            n_checks++;
        end
        for (int k = 0; k < 4; k++) begin
            if (ram[16'h0100 + 16'(k)] !== d[k]) begin
                n_fail++;
                $display("FAIL reg2ram data[%0d]: got %h expected %h", k, ram[16'h0100 + 16'(k)], d[k]);
            end
            n_checks++;
        end
    endtask

    task automatic test_ram2reg;
        logic [31:0] e [1:6];
        logic [31:0] m [1:6];
        logic [7:0]  d [0:2];
        e[1] = pk(2'b01, 16'h0020, 0, 0, 0, 5'd0,  1, 0); m[1] = M_M2R0;
        e[2] = pk(2'b01, 16'h0021, 0, 0, 1, 5'd10, 1, 0); m[2] = M_M2R;
        e[3] = pk(2'b01, 16'h0022, 0, 0, 1, 5'd11, 1, 0); m[3] = M_M2R;
        e[4] = pk(2'b01, 16'h0022, 0, 0, 1, 5'd12, 1, 0); m[4] = M_M2R;
        e[5] = DONE_V;                                    m[5] = M_CTRL;
        e[6] = IDLE_V;                                    m[6] = M_ALL;
        d[0] = 8'h0A; d[1] = 8'h0B; d[2] = 8'h0C;
        @(negedge clk);
        request(1'b1, 5'd10, 16'h0020, 6'd3);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if ((obs & m[c]) !== (e[c] & m[c])) begin
                n_fail++;
                $display("FAIL ram2reg c%0d: got %h expected %h", c, obs & m[c], e[c] & m[c]);
            end
            n_checks++;
        end
        for (int k = 0; k < 3; k++) begin
            if (rf[10 + k] !== d[k]) begin
                n_fail++;
                $display("FAIL ram2reg r%0d: got %h expected %h", 10 + k, rf[10 + k], d[k]);
            end
            n_checks++;
        end
    endtask

    task automatic test_wrap;
        logic [31:0] e [1:6];
        logic [31:0] m [1:6];
        e[1] = pk(2'b01, 16'hFFFF, 0, 0, 0, 5'd0,  1, 0); m[1] = M_M2R0;
        e[2] = pk(2'b01, 16'h0000, 0, 0, 1, 5'd30, 1, 0); m[2] = M_M2R;
        e[3] = pk(2'b01, 16'h0001, 0, 0, 1, 5'd31, 1, 0); m[3] = M_M2R;
        e[4] = pk(2'b01, 16'h0001, 0, 0, 1, 5'd0,  1, 0); m[4] = M_M2R;
        e[5] = DONE_V;                                    m[5] = M_CTRL;
        e[6] = IDLE_V;                                    m[6] = M_ALL;
        @(negedge clk);
        request(1'b1, 5'd30, 16'hFFFF, 6'd3);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if ((obs & m[c]) !== (e[c] & m[c])) begin
                n_fail++;
                $display("FAIL wrap c%0d: got %h expected %h", c, obs & m[c], e[c] & m[c]);
            end
            n_checks++;
        end
        if (rf[30] !== 8'h5A) begin
            n_fail++;
            $display("FAIL wrap r30: got %h expected 5a", rf[30]);
        end
        n_checks++;
        if (rf[31] !== 8'h6B) begin
            n_fail++;
            $display("FAIL wrap r31: got %h expected 6b", rf[31]);
        end
        n_checks++;
        if (rf[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap r0: got %h expected 00", rf[0]);
        end
        n_checks++;
    endtask

    task automatic test_count_zero;
        @(negedge clk);
        request(1'b0, 5'd4, 16'h0400, 6'd0);
        @(negedge clk);
        bus.start = 1'b0;
        if ((obs & M_CTRL) !== DONE_V) begin
            n_fail++;
            $display("FAIL count0 c1: got %h expected %h", obs & M_CTRL, DONE_V);
        end
        n_checks++;
        @(negedge clk);
        if (obs !== IDLE_V) begin
            n_fail++;
            $display("FAIL count0 c2: got %h expected %h", obs, IDLE_V);
        end
        n_checks++;
        if (ram[16'h0400] !== 8'h00) begin
            n_fail++;
            $display("FAIL count0 data: got %h expected 00", ram[16'h0400]);
        end
        n_checks++;
    endtask

    task automatic test_start_while_busy;
        logic [31:0] e [1:5];
        logic [31:0] m [1:5];
        e[1] = pk(2'b00, 16'h0200, 1, 5'd4, 0, 0, 1, 0); m[1] = M_R2M;
        e[2] = pk(2'b00, 16'h0201, 1, 5'd5, 0, 0, 1, 0); m[2] = M_R2M;
        e[3] = DONE_V;                                   m[3] = M_CTRL;
        e[4] = IDLE_V;                                   m[4] = M_ALL;
        e[5] = IDLE_V;                                   m[5] = M_ALL;
        @(negedge clk);
        request(1'b0, 5'd4, 16'h0200, 6'd2);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 1) request(1'b1, 5'd9, 16'h0500, 6'd5);
            if ((obs & m[c]) !== (e[c] & m[c])) begin
                n_fail++;
                $display("FAIL busy_start c%0d: got %h expected %h", c, obs & m[c], e[c] & m[c]);
            end
            n_checks++;
        end
        if (ram[16'h0200] !== 8'h11 || ram[16'h0201] !== 8'h22) begin
            n_fail++;
            $display("FAIL busy_start data: got %h %h expected 11 22", ram[16'h0200], ram[16'h0201]);
        end
        n_checks++;
    endtask

    task automatic test_abort;
        logic [31:0] e [1:5];
        logic [31:0] m [1:5];
        logic [7:0]  d [0:2];
        e[1] = pk(2'b00, 16'h0300, 1, 5'd4, 0, 0, 1, 0); m[1] = M_R2M;
        e[2] = pk(2'b00, 16'h0301, 1, 5'd5, 0, 0, 1, 0); m[2] = M_R2M;
        e[3] = IDLE_V;                                   m[3] = M_ALL;
        e[4] = IDLE_V;                                   m[4] = M_ALL;
        e[5] = IDLE_V;                                   m[5] = M_ALL;
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'hEE;
        @(negedge clk);
        request(1'b0, 5'd4, 16'h0300, 6'd6);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if ((obs & m[c]) !== (e[c] & m[c])) begin
                n_fail++;
                $display("FAIL abort c%0d: got %h expected %h", c, obs & m[c], e[c] & m[c]);
            end
            n_checks++;
            rst = (c == 2);
        end
        for (int k = 0; k < 3; k++) begin
            if (ram[16'h0300 + 16'(k)] !== d[k]) begin
                n_fail++;
                $display("FAIL abort data[%0d]: got %h expected %h", k, ram[16'h0300 + 16'(k)], d[k]);
            end
            n_checks++;
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        pl_rf_en     = 1'b0;
        pl_ram_en    = 1'b0;
        pl_addr      = '0;
        pl_data      = '0;
        bus.start    = 1'b0;
        bus.dir      = 1'b0;
        bus.reg_base = '0;
        bus.ram_base = '0;
        bus.count    = '0;

        test_reset;

        preload(1'b0, 16'd0,  8'h00);
        preload(1'b0, 16'd4,  8'h11);
        preload(1'b0, 16'd5,  8'h22);
        preload(1'b0, 16'd6,  8'h33);
        preload(1'b0, 16'd7,  8'h44);
        preload(1'b0, 16'd10, 8'h00);
        preload(1'b0, 16'd11, 8'h00);
        preload(1'b0, 16'd12, 8'h00);
        preload(1'b0, 16'd30, 8'h00);
        preload(1'b0, 16'd31, 8'h00);
        preload(1'b1, 16'h0020, 8'h0A);
        preload(1'b1, 16'h0021, 8'h0B);
        preload(1'b1, 16'h0022, 8'h0C);
        preload(1'b1, 16'hFFFF, 8'h5A);
        preload(1'b1, 16'h0000, 8'h6B);
        preload(1'b1, 16'h0001, 8'h7C);
        preload(1'b1, 16'h0400, 8'h00);
        preload(1'b1, 16'h0300, 8'hEE);
        preload(1'b1, 16'h0301, 8'hEE);
        preload(1'b1, 16'h0302, 8'hEE);

        test_reg2ram;
        test_ram2reg;
        test_wrap;
        test_count_zero;
        test_start_while_busy;
        test_abort;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_xfer_ctrl.md
# ram_xfer_ctrl

Sequencer that moves a block of words between the register file and the block RAM through the existing RAM/regfile datapath wrapper. It sits upstream of that wrapper and is the initiator on its control port. It drives the wrapper's mode select, addresses and write enables cycle by cycle, so software or a test harness can request an N-word copy with one start pulse instead of hand-toggling the wrapper.

## Interface
Parameters:
- REG_AW, default 5: register-file address width (32 registers).
- RAM_AW, default 16: block-RAM address width.
- CNT_W, default 6: transfer-count width; legal count is 0..32.

Ports:
- clk  in  1  clock; the only clock in the block.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- dir  in  1  0 = reg→ram, 1 = ram→reg; latched on accepted start.
- reg_base  in  REG_AW  first register index; latched on accepted start.
- ram_base  in  RAM_AW  first RAM word address; latched on accepted start.
- count  in  CNT_W  number of words; latched on accepted start.
- choice  out  2  wrapper mode: 2'b00 reg→ram, 2'b01 ram→reg, 2'b10 idle.
- ram_addr  out  RAM_AW  block-RAM address.
- ram_wen  out  1  block-RAM write enable.
- raddr1  out  REG_AW  regfile read port 1 address (reg→ram source).
- we  out  1  regfile write enable.
- waddr  out  REG_AW  regfile write address.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, R2M, M2R, DONE.
- IDLE:
  - choice=2'b10; ram_wen=0, we=0, busy=0, done=0; addresses 0.
  - start=1 latches dir, bases and count, and clears index i.
  - If count=0, go to DONE.
  - Otherwise go to R2M (dir=0) or M2R (dir=1).
- R2M, one word per cycle:
  - choice=00, raddr1=reg_base+i, ram_addr=ram_base+i, ram_wen=1, busy=1.
  - The wrapper routes the combinational rdata1 to the RAM write data, so the write commits on the same edge.
  - i increments each cycle. After the cycle with i=count-1, go to DONE.
- M2R, pipelined for the block RAM's 1-cycle read latency:
  - Runs for count+1 cycles, j=0..count. In every cycle choice=01 and busy=1.
  - Read issue: for j<count, ram_addr=ram_base+j. In the final cycle j=count, ram_addr holds its last value.
  - Write-back: for j≥1, we=1 and waddr=reg_base+j-1, which writes the RAM data addressed in the previous cycle. For j=0, we=0.
  - After j=count, go to DONE.
  - ram_wen stays 0 throughout.
- DONE: done=1 for exactly one cycle, busy=0, choice=10, no enables. Next state is IDLE.
- Address arithmetic: reg index wraps mod 2^REG_AW (e.g. base 30, count 4 → 30, 31, 0, 1). RAM address wraps mod 2^RAM_AW.
- Writes to register 0 are issued as normal; discarding them is the regfile's job.
- start outside IDLE is ignored. Inputs are not re-sampled mid-transfer.
- count > 32 is out of range; the block transfers count mod 2^CNT_W words with no checking.
- Reset:
  - rst=1 at any edge forces IDLE, i=0, and every output to its IDLE value.
  - Reset takes priority over start.
  - Reset mid-transfer aborts without a done pulse. Writes already committed stay committed.

## Timing
- All outputs are Moore decodes of the registered state and index, so there is no combinational path from inputs to outputs.
- start is accepted at edge E0:
  - R2M: busy=1 in cycles 1..N, done in cycle N+1, IDLE in cycle N+2.
  - M2R: busy=1 in cycles 1..N+1, done in cycle N+2.
  - count=0: done in cycle 1, no enables asserted.
- Throughput: 1 word/cycle. Back-to-back transfers: the next start can be accepted in the first IDLE cycle after DONE.

## Structure
- Shared package xfer_pkg holds:
  - the state enum (IDLE, R2M, M2R, DONE);
  - choice constants CH_REG2RAM=2'b00, CH_RAM2REG=2'b01, CH_IDLE=2'b10.
- No sub-module is needed; the FSM and index counter live in one module.
- The top level instantiates ram_xfer_ctrl beside the existing wrapper and connects the ports one-to-one.

## Test plan
- Reset: hold rst 3 cycles, then start=1 in the same cycle as rst=1 → choice=10, busy=0, done=0, no enables, start ignored.
- reg→ram: preload r4..r7 = 0x11,0x22,0x33,0x44; dir=0, reg_base=4, ram_base=0x0100, count=4 → ram_wen high in cycles 1–4 with ram_addr 0x100..0x103. RAM[0x100..0x103] = 0x11..0x44. done in cycle 5.
- ram→reg: RAM[0x20..0x22] = 0xA,0xB,0xC; dir=1, reg_base=10, ram_base=0x20, count=3 → we high in cycles 2–4 with waddr 10,11,12. r10..r12 = 0xA,0xB,0xC. done in cycle 5.
- Wrap: dir=1, reg_base=30, ram_base=0xFFFF, count=3 → ram_addr 0xFFFF, 0x0000, 0x0001. waddr 30, 31, 0. r0 remains 0.
- count=0 and a start asserted while busy: count=0 → done in cycle 1 with no writes. A second start during R2M → ignored; the first transfer completes unchanged.
- Abort: rst asserted in cycle 2 of a 6-word R2M → IDLE next cycle, no done pulse, only the first 2 RAM words written.
